imm_gen: RTL and testbench

IMM_GEN -- requirements
Module: imm_gen

---
 rtl/imm_gen_if.sv | 24 ++
 rtl/imm_gen.sv | 114 +++++++++++
 tb/tb_imm_gen.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/imm_gen_if.sv
// Immediate-generator bus: instruction in, combinational and registered immediates out.
interface imm_gen_if;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;

  logic [XLEN-1:0]  instr;
  logic             in_valid;
  logic [XLEN-1:0]  imm;
  logic [FMT_W-1:0] imm_fmt;
  logic             imm_unknown;
  logic [XLEN-1:0]  imm_q;
  logic [FMT_W-1:0] fmt_q;
  logic             out_valid;

  modport master (
    output instr, in_valid,
    input  imm, imm_fmt, imm_unknown, imm_q, fmt_q, out_valid
  );

  modport slave (
    input  instr, in_valid,
    output imm, imm_fmt, imm_unknown, imm_q, fmt_q, out_valid
  );
endinterface

// File: rtl/imm_gen.sv
// RV32I immediate generator: combinational decode plus an optional one-cycle registered copy.
// Define IMM_GEN_REG_OUT_EN to build the registered path; otherwise imm_q/fmt_q/out_valid are tied to 0.
module imm_gen (
  input  logic       clk,
  input  logic       rst,
  imm_gen_if.slave   bus
);
  localparam int unsigned XLEN  = 32;
  localparam int unsigned FMT_W = 3;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [FMT_W-1:0] FMT_NONE = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I    = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S    = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B    = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U    = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J    = 3'd5;

  logic [XLEN-1:0]  instr;
  logic [XLEN-1:0]  imm_c;
  logic [FMT_W-1:0] fmt_c;
  logic             unknown_c;
  logic             sgn;

  assign instr = bus.instr;
  assign sgn   = instr[31];

  // Opcode decode; non-32-bit encodings (instr[1:0] != 11) fall into the unknown bucket.
  always_comb begin
    imm_c     = '0;
    fmt_c     = FMT_NONE;
    unknown_c = 1'b0;
    if (instr[1:0] != 2'b11) begin
      unknown_c = 1'b1;
    end else begin
      unique case (instr[6:0])
        OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
          imm_c = {{20{sgn}}, instr[31:20]};
          fmt_c = FMT_I;
        end
        OP_STORE: begin
          imm_c = {{20{sgn}}, instr[31:25], instr[11:7]};
          fmt_c = FMT_S;
        end
        OP_BRANCH: begin
          imm_c = {{19{sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt_c = FMT_B;
        end
        OP_LUI, OP_AUIPC: begin
          imm_c = {instr[31:12], 12'b0};
          fmt_c = FMT_U;
        end
        OP_JAL: begin
          imm_c = {{11{sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt_c = FMT_J;
        end
        OP_OP, OP_FENCE: begin
          imm_c = '0;
        end
        default: begin
          unknown_c = 1'b1;
        end
      endcase
    end
  end

  assign bus.imm         = imm_c;
  assign bus.imm_fmt     = fmt_c;
  assign bus.imm_unknown = unknown_c;

`ifdef IMM_GEN_REG_OUT_EN
  logic [XLEN-1:0]  imm_q;
  logic [FMT_W-1:0] fmt_q;
  logic             out_valid;

  // Capture on in_valid; out_valid is a one-cycle pulse per capture, data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imm_q     <= '0;
      fmt_q     <= '0;
      out_valid <= 1'b0;
    end else if (bus.in_valid) begin
      imm_q     <= imm_c;
      fmt_q     <= fmt_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

  assign bus.imm_q     = imm_q;
  assign bus.fmt_q     = fmt_q;
  assign bus.out_valid = out_valid;
`else
  logic unused_reg_path;
  assign unused_reg_path = clk ^ rst ^ bus.in_valid;

  assign bus.imm_q     = '0;
  assign bus.fmt_q     = '0;
  assign bus.out_valid = 1'b0;
`endif

endmodule

// File: tb/tb_imm_gen.sv
// Scoreboard bench for imm_gen: driver queues expectations, monitors pop and compare.
module tb_imm_gen;
  typedef struct {
    string       name;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        unk;
  } exp_t;

  logic clk;
  logic rst;
  imm_gen_if bus();

  imm_gen dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t comb_q[$];
  exp_t reg_q[$];
  event comb_ev;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Apply an instruction and queue its expected combinational decode.
  task automatic apply(input string name, input logic [31:0] ins,
                       input logic [31:0] eimm, input logic [2:0] efmt, input logic eunk);
    exp_t e;
    e.name = name; e.imm = eimm; e.fmt = efmt; e.unk = eunk;
    bus.instr = ins;
    comb_q.push_back(e);
    #1;
    -> comb_ev;
    #1;
  endtask

  task automatic push_reg(input string name, input logic [31:0] eimm, input logic [2:0] efmt);
    exp_t e;
    e.name = name; e.imm = eimm; e.fmt = efmt; e.unk = 1'b0;
    reg_q.push_back(e);
  endtask

  // Combinational monitor.
  initial begin
    exp_t e;
    forever begin
      @(comb_ev);
      n_vec++;
      if (comb_q.size() == 0) begin
        n_bad++;
        $display("FAIL comb_underflow: got imm 0x%08h with no expectation queued", bus.imm);
      end else begin
        e = comb_q.pop_front();
        if (bus.imm !== e.imm || bus.imm_fmt !== e.fmt || bus.imm_unknown !== e.unk) begin
          n_bad++;
          $display("FAIL %s: got imm 0x%08h fmt %0d unk %b expected imm 0x%08h fmt %0d unk %b",
                   e.name, bus.imm, bus.imm_fmt, bus.imm_unknown, e.imm, e.fmt, e.unk);
        end
      end
    end
  end

  // Registered-path monitor, sampling on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (reg_q.size() == 0) begin
          n_bad++;
          $display("FAIL reg_unexpected: got out_valid 1 imm_q 0x%08h expected no capture", bus.imm_q);
        end else begin
          e = reg_q.pop_front();
          if (bus.imm_q !== e.imm || bus.fmt_q !== e.fmt) begin
            n_bad++;
            $display("FAIL %s: got imm_q 0x%08h fmt_q %0d expected imm_q 0x%08h fmt_q %0d",
                     e.name, bus.imm_q, bus.fmt_q, e.imm, e.fmt);
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.instr = 32'h0;
    bus.in_valid = 1'b0;
    #3;
    chk("rst_imm_q", bus.imm_q, 32'h0);
    chk("rst_fmt_q", 32'(bus.fmt_q), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    // Combinational path must decode while reset is held.
    apply("ld_in_reset", 32'h0080af03, 32'h00000008, 3'd1, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    apply("ld_pos8",    32'h0080af03, 32'h00000008, 3'd1, 1'b0);
    apply("ld_neg8",    32'hff80af03, 32'hfffffff8, 3'd1, 1'b0);
    apply("ld_32",      32'h0200a283, 32'h00000020, 3'd1, 1'b0);
    apply("jalr_neg4",  32'hffc08067, 32'hfffffffc, 3'd1, 1'b0);
    apply("st_4",       32'h0020a223, 32'h00000004, 3'd2, 1'b0);
    apply("st_neg12",   32'hfe20aa23, 32'hfffffff4, 3'd2, 1'b0);
    apply("st_0",       32'h0020a023, 32'h00000000, 3'd2, 1'b0);
    apply("br_8",       32'h00208463, 32'h00000008, 3'd3, 1'b0);
    apply("br_12",      32'h00208663, 32'h0000000c, 3'd3, 1'b0);
    apply("br_neg14",   32'hfeb289e3, 32'hfffffff2, 3'd3, 1'b0);
    apply("lui",        32'h123452b7, 32'h12345000, 3'd4, 1'b0);
    apply("auipc",      32'h00001297, 32'h00001000, 3'd4, 1'b0);
    apply("jal_neg4",   32'hffdff0ef, 32'hfffffffc, 3'd5, 1'b0);
    apply("r_type",     32'h00000033, 32'h00000000, 3'd0, 1'b0);
    apply("fence",      32'h0000000f, 32'h00000000, 3'd0, 1'b0);
    apply("op_unknown", 32'h0000007f, 32'h00000000, 3'd0, 1'b1);
    apply("low_bits",   32'hfff00011, 32'h00000000, 3'd0, 1'b1);

`ifdef IMM_GEN_REG_OUT_EN
    @(posedge clk); #2;
    bus.instr = 32'hff80af03;
    bus.in_valid = 1'b1;
    push_reg("reg_ld_neg8", 32'hfffffff8, 3'd1);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    bus.instr = 32'h0020a223;
    @(posedge clk); #2;
    chk("hold_out_valid", 32'(bus.out_valid), 32'h0);
    chk("hold_imm_q", bus.imm_q, 32'hfffffff8);
    chk("hold_fmt_q", 32'(bus.fmt_q), 32'h1);

    bus.instr = 32'hfe20aa23;
    bus.in_valid = 1'b1;
    push_reg("reg_st_neg12", 32'hfffffff4, 3'd2);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_imm_q", bus.imm_q, 32'h0);
    chk("async_rst_fmt_q", 32'(bus.fmt_q), 32'h0);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'h0);
    apply("br_in_reset", 32'h00208463, 32'h00000008, 3'd3, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("post_rst_idle_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_idle_imm_q", bus.imm_q, 32'h0);
    bus.instr = 32'h123452b7;
    bus.in_valid = 1'b1;
    push_reg("reg_lui_first", 32'h12345000, 3'd4);
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
`else
    @(posedge clk); #2;
    bus.instr = 32'hff80af03;
    bus.in_valid = 1'b1;
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    chk("tied_imm_q", bus.imm_q, 32'h0);
    chk("tied_fmt_q", 32'(bus.fmt_q), 32'h0);
    chk("tied_out_valid", 32'(bus.out_valid), 32'h0);
    @(posedge clk); #2;
`endif

    chk("comb_queue_drained", 32'(comb_q.size()), 32'h0);
    chk("reg_queue_drained", 32'(reg_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
